// File: rtl/bc_turn_ctrl.sv
// Bulls & Cows game-flow controller: secret entry, alternating guesses, result
// display and win handling, sharing one external bulls/cows comparator via req/ack.

module bc_digit_chk (
  input  logic [3:0] dig,
  output logic       ok
);
  assign ok = (dig <= 4'd9);
endmodule

module bc_turn_ctrl #(
  parameter int DISPLAY_CYCLES = 200000000,
  parameter int ATT_W          = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      sw,
  input  logic             confirm,
  output logic             cmp_req,
  input  logic             cmp_ack,
  output logic [15:0]      cmp_secret,
  output logic [15:0]      cmp_guess,
  input  logic [2:0]       cmp_bulls,
  input  logic [2:0]       cmp_cows,
  output logic [2:0]       state,
  output logic             active_player,
  output logic [2:0]       bulls,
  output logic [2:0]       cows,
  output logic             win_flag,
  output logic             winner,
  output logic             err_flag,
  output logic [ATT_W-1:0] attempts_j1,
  output logic [ATT_W-1:0] attempts_j2
);
  localparam int NUM_DIG = 4;
  localparam int TW = (DISPLAY_CYCLES > 2) ? $clog2(DISPLAY_CYCLES) : 1;
  localparam logic [TW-1:0]    T_LAST  = TW'(DISPLAY_CYCLES - 1);
  localparam logic [ATT_W-1:0] ATT_MAX = {ATT_W{1'b1}};

  typedef enum logic [2:0] {
    S_SECRET_J1 = 3'd0, S_SECRET_J2 = 3'd1, S_GUESS_J1 = 3'd2, S_GUESS_J2 = 3'd3,
    S_DISP_J1   = 3'd4, S_DISP_J2   = 3'd5, S_WIN      = 3'd6, S_FIM      = 3'd7
  } st_e;

  st_e              state_q, state_d;
  logic [15:0]      secret_j1_q, secret_j1_d, secret_j2_q, secret_j2_d;
  logic [15:0]      guess_q, guess_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             req_q, req_d, ap_q, ap_d;
  logic [2:0]       bulls_q, bulls_d, cows_q, cows_d;
  logic             win_q, win_d, winner_q, winner_d, err_q, err_d;
  logic [ATT_W-1:0] att1_q, att1_d, att2_q, att2_d;

  logic [NUM_DIG-1:0] dig_ok;
  logic               bcd_ok, distinct_ok;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bc_digit_chk u_chk (.dig(sw[4*g +: 4]), .ok(dig_ok[g]));
  end

  assign bcd_ok      = &dig_ok;
  assign distinct_ok = (sw[15:12] != sw[11:8]) && (sw[15:12] != sw[7:4]) &&
                       (sw[15:12] != sw[3:0])  && (sw[11:8]  != sw[7:4]) &&
                       (sw[11:8]  != sw[3:0])  && (sw[7:4]   != sw[3:0]);

  always_comb begin
    state_d     = state_q;
    secret_j1_d = secret_j1_q;
    secret_j2_d = secret_j2_q;
    guess_d     = guess_q;
    timer_d     = timer_q;
    req_d       = req_q;
    ap_d        = ap_q;
    bulls_d     = bulls_q;
    cows_d      = cows_q;
    win_d       = win_q;
    winner_d    = winner_q;
    err_d       = err_q;
    att1_d      = att1_q;
    att2_d      = att2_q;
    case (state_q)
      S_SECRET_J1, S_SECRET_J2: begin
        if (confirm) begin
          if (bcd_ok && distinct_ok) begin
            err_d = 1'b0;
            if (state_q == S_SECRET_J1) begin
              secret_j1_d = sw;
              state_d     = S_SECRET_J2;
              ap_d        = 1'b1;
            end else begin
              secret_j2_d = sw;
              state_d     = S_GUESS_J1;
              ap_d        = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GUESS_J1, S_GUESS_J2: begin
        // While a request is outstanding, confirm is ignored so operands stay frozen
        if (req_q) begin
          if (cmp_ack) begin
            req_d   = 1'b0;
            bulls_d = cmp_bulls;
            cows_d  = cmp_cows;
            timer_d = '0;
            if (state_q == S_GUESS_J1) begin
              if (att1_q != ATT_MAX) att1_d = att1_q + 1'b1;
            end else begin
              if (att2_q != ATT_MAX) att2_d = att2_q + 1'b1;
            end
            if (cmp_bulls == 3'd4) begin
              state_d  = S_WIN;
              winner_d = ap_q;
              win_d    = 1'b1;
            end else begin
              state_d = (state_q == S_GUESS_J1) ? S_DISP_J1 : S_DISP_J2;
            end
          end
        end else if (confirm) begin
          if (bcd_ok) begin
            err_d   = 1'b0;
            guess_d = sw;
            req_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DISP_J1, S_DISP_J2: begin
        if (confirm || (timer_q == T_LAST)) begin
          state_d = (state_q == S_DISP_J1) ? S_GUESS_J2 : S_GUESS_J1;
          ap_d    = ~ap_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WIN: begin
        if (timer_q == T_LAST) state_d = S_FIM;
        else                   timer_d = timer_q + 1'b1;
      end
      S_FIM: begin
        if (confirm) begin
          state_d     = S_SECRET_J1;
          secret_j1_d = '0;
          secret_j2_d = '0;
          timer_d     = '0;
          bulls_d     = '0;
          cows_d      = '0;
          win_d       = 1'b0;
          winner_d    = 1'b0;
          err_d       = 1'b0;
          att1_d      = '0;
          att2_d      = '0;
          ap_d        = 1'b0;
        end
      end
      default: state_d = S_SECRET_J1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_SECRET_J1;
      secret_j1_q <= '0;
      secret_j2_q <= '0;
      guess_q     <= '0;
      timer_q     <= '0;
      req_q       <= 1'b0;
      ap_q        <= 1'b0;
      bulls_q     <= '0;
      cows_q      <= '0;
      win_q       <= 1'b0;
      winner_q    <= 1'b0;
      err_q       <= 1'b0;
      att1_q      <= '0;
      att2_q      <= '0;
    end else begin
      state_q     <= state_d;
      secret_j1_q <= secret_j1_d;
      secret_j2_q <= secret_j2_d;
      guess_q     <= guess_d;
      timer_q     <= timer_d;
      req_q       <= req_d;
      ap_q        <= ap_d;
      bulls_q     <= bulls_d;
      cows_q      <= cows_d;
      win_q       <= win_d;
      winner_q    <= winner_d;
      err_q       <= err_d;
      att1_q      <= att1_d;
      att2_q      <= att2_d;
    end
  end

  // The guesser is scored against the opponent's secret
  assign cmp_secret    = ap_q ? secret_j1_q : secret_j2_q;
  assign cmp_guess     = guess_q;
  assign cmp_req       = req_q;
  assign state         = state_q;
  assign active_player = ap_q;
  assign bulls         = bulls_q;
  assign cows          = cows_q;
  assign win_flag      = win_q;
  assign winner        = winner_q;
  assign err_flag      = err_q;
  assign attempts_j1   = att1_q;
  assign attempts_j2   = att2_q;

endmodule

// File: tb/tb_bc_turn_ctrl.sv
// Directed bench for bc_turn_ctrl with short display time and 2-bit attempt counters.

module tb_bc_turn_ctrl;
  localparam int DC = 8;
  localparam int AW = 2;

  logic          clock, reset, confirm, cmp_ack, cmp_req;
  logic [15:0]   sw, cmp_secret, cmp_guess;
  logic [2:0]    cmp_bulls, cmp_cows, state, bulls, cows;
  logic          active_player, win_flag, winner, err_flag;
  logic [AW-1:0] attempts_j1, attempts_j2;

  int checks   = 0;
  int failures = 0;

  bc_turn_ctrl #(.DISPLAY_CYCLES(DC), .ATT_W(AW)) dut (
    .clock(clock), .reset(reset), .sw(sw), .confirm(confirm),
    .cmp_req(cmp_req), .cmp_ack(cmp_ack), .cmp_secret(cmp_secret), .cmp_guess(cmp_guess),
    .cmp_bulls(cmp_bulls), .cmp_cows(cmp_cows), .state(state), .active_player(active_player),
    .bulls(bulls), .cows(cows), .win_flag(win_flag), .winner(winner), .err_flag(err_flag),
    .attempts_j1(attempts_j1), .attempts_j2(attempts_j2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [15:0] v);
    sw      = v;
    confirm = 1'b1;
    step();
    confirm = 1'b0;
  endtask

  task automatic ack(input logic [2:0] b, input logic [2:0] c);
    cmp_bulls = b;
    cmp_cows  = c;
    cmp_ack   = 1'b1;
    step();
    cmp_ack   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sw = '0; confirm = 1'b0; cmp_ack = 1'b0; cmp_bulls = '0; cmp_cows = '0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_req", 32'(cmp_req), 0);
    chk("rst_err", 32'(err_flag), 0);
    chk("rst_win", 32'(win_flag), 0);
    chk("rst_att", 32'({attempts_j1, attempts_j2}), 0);
    chk("rst_bc", 32'({bulls, cows}), 0);
    reset = 1'b1;
    step();
    chk("idle_state", 32'(state), 0);

    // Secret validation
    press(16'h1123);
    chk("dup_err", 32'(err_flag), 1);
    chk("dup_state", 32'(state), 0);
    press(16'h12A4);
    chk("bcd_err", 32'(err_flag), 1);
    chk("bcd_state", 32'(state), 0);
    press(16'h9012);
    chk("ok_err", 32'(err_flag), 0);
    chk("ok_state", 32'(state), 1);
    chk("ok_ap", 32'(active_player), 1);

    #2 reset = 1'b0;
    #2 reset = 1'b1;
    step();
    chk("rst2_state", 32'(state), 0);

    press(16'h1234);
    chk("s1_state", 32'(state), 1);
    chk("s1_ap", 32'(active_player), 1);
    press(16'h5678);
    chk("s2_state", 32'(state), 2);
    chk("s2_ap", 32'(active_player), 0);
    chk("s2_err", 32'(err_flag), 0);

    // J1 guess, held handshake with confirm noise
    press(16'h5687);
    chk("g1_req", 32'(cmp_req), 1);
    chk("g1_sec", 32'(cmp_secret), 32'h5678);
    chk("g1_guess", 32'(cmp_guess), 32'h5687);
    for (int i = 0; i < 5; i++) begin
      sw = 16'h1111;
      confirm = (i % 2 == 0);
      step();
      chk("hold_req", 32'(cmp_req), 1);
      chk("hold_guess", 32'(cmp_guess), 32'h5687);
      chk("hold_sec", 32'(cmp_secret), 32'h5678);
    end
    confirm = 1'b0;
    ack(3'd2, 3'd2);
    chk("a1_bulls", 32'(bulls), 2);
    chk("a1_cows", 32'(cows), 2);
    chk("a1_att", 32'(attempts_j1), 1);
    chk("a1_state", 32'(state), 4);
    chk("a1_req", 32'(cmp_req), 0);

    for (int i = 0; i < DC - 1; i++) step();
    chk("d1_hold", 32'(state), 4);
    chk("d1_bulls", 32'(bulls), 2);
    step();
    chk("d1_end", 32'(state), 3);
    chk("d1_ap", 32'(active_player), 1);

    // J2 guess, display cut short on its second cycle
    press(16'h0000);
    chk("g2_sec", 32'(cmp_secret), 32'h1234);
    ack(3'd1, 3'd0);
    chk("a2_state", 32'(state), 5);
    chk("a2_att", 32'(attempts_j2), 1);
    step();
    chk("d2_cyc1", 32'(state), 5);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    chk("d2_skip", 32'(state), 2);
    chk("d2_ap", 32'(active_player), 0);

    // J1 misses, J2 wins
    press(16'h0000);
    ack(3'd0, 3'd1);
    chk("a3_att", 32'(attempts_j1), 2);
    press(16'h0000);
    chk("a3_skip", 32'(state), 3);
    press(16'h1234);
    ack(3'd4, 3'd0);
    chk("w_state", 32'(state), 6);
    chk("w_flag", 32'(win_flag), 1);
    chk("w_winner", 32'(winner), 1);
    chk("w_att2", 32'(attempts_j2), 2);
    confirm = 1'b1;
    step();
    confirm = 1'b0;
    for (int i = 0; i < DC - 2; i++) step();
    chk("w_hold", 32'(state), 6);
    step();
    chk("fim_state", 32'(state), 7);
    chk("fim_win", 32'(win_flag), 1);
    chk("fim_bulls", 32'(bulls), 4);
    press(16'h0000);
    chk("new_state", 32'(state), 0);
    chk("new_flags", 32'({win_flag, winner, err_flag, active_player}), 0);
    chk("new_att", 32'({attempts_j1, attempts_j2}), 0);
    chk("new_bc", 32'({bulls, cows}), 0);

    // Saturation of 2-bit counters
    press(16'h1234);
    press(16'h5678);
    press(16'h12F4);
    chk("gerr_err", 32'(err_flag), 1);
    chk("gerr_req", 32'(cmp_req), 0);
    for (int r = 1; r <= 4; r++) begin
      press(16'h0000);
      ack(3'd0, 3'd0);
      chk("sat_j1", 32'(attempts_j1), (r > 3) ? 3 : r);
      press(16'h0000);
      press(16'h0000);
      ack(3'd1, 3'd1);
      press(16'h0000);
    end
    chk("sat_j2", 32'(attempts_j2), 3);
    chk("sat_state", 32'(state), 2);

    // Reset during an outstanding request
    press(16'h5687);
    chk("mr_req", 32'(cmp_req), 1);
    #2 reset = 1'b0;
    #1;
    chk("mr_req_drop", 32'(cmp_req), 0);
    chk("mr_state", 32'(state), 0);
    #2 reset = 1'b1;
    step();
    ack(3'd4, 3'd0);
    chk("late_state", 32'(state), 0);
    chk("late_bulls", 32'(bulls), 0);
    chk("late_win", 32'(win_flag), 0);
    chk("late_att", 32'(attempts_j1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
